// File: rtl/id_fwd_stage.sv
// Decode-stage pipeline slot: IF->ID register, operand forwarding, interlock, branch resolve.
// Optional interlock-cycle counter enabled by defining ID_STALL_CNT_EN.
module id_fwd_stage #(
    parameter int NUM_FWD = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   if_id_valid,
    output logic                   id_allowin,
    input  logic [63:0]            if_id_bus,
    output logic                   id_exe_valid,
    input  logic                   exe_allowin,
    input  logic                   flush,
    output logic [31:0]            id_pc,
    output logic [31:0]            id_inst,
    input  logic                   dec_rj_used,
    input  logic                   dec_rk_used,
    input  logic                   dec_rd_src,
    input  logic [2:0]             dec_br_op,
    input  logic [31:0]            dec_br_target,
    output logic [4:0]             rf_raddr1,
    output logic [4:0]             rf_raddr2,
    input  logic [31:0]            rf_rdata1,
    input  logic [31:0]            rf_rdata2,
    input  logic [NUM_FWD*39-1:0]  fwd_bus,
    output logic [31:0]            rj_value,
    output logic [31:0]            rkd_value,
    output logic [32:0]            id_if_bus,
    output logic [31:0]            stall_cnt
);

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_inst;

    logic [32:0] w_res1;
    logic [32:0] w_res2;
    logic        w_blk1;
    logic        w_blk2;
    logic        w_ready_go;
    logic        w_cond;
    logic        w_lt_s;
    logic        w_lt_u;
    logic        w_eq;
    logic        w_br_taken;
    logic        w_capture;

    // Returns {blocked, value}. Scanning from the lowest-priority channel up
    // lets the highest-priority match overwrite any older one.
    function automatic logic [32:0] resolve(
        input logic [4:0]             a,
        input logic                   used,
        input logic [31:0]            rf,
        input logic [NUM_FWD*39-1:0]  fb
    );
        logic [32:0] r;
        r = {1'b0, (a == 5'd0) ? 32'h0 : rf};
        if (used && a != 5'd0) begin
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (fb[39*k+38] && fb[39*k+32 +: 5] == a)
                    r = {fb[39*k+37], fb[39*k +: 32]};
            end
        end
        return r;
    endfunction

    assign rf_raddr1 = r_inst[9:5];
    assign rf_raddr2 = dec_rd_src ? r_inst[4:0] : r_inst[14:10];

    assign w_res1 = resolve(rf_raddr1, dec_rj_used, rf_rdata1, fwd_bus);
    assign w_res2 = resolve(rf_raddr2, dec_rk_used, rf_rdata2, fwd_bus);

    assign w_blk1    = w_res1[32];
    assign w_blk2    = w_res2[32];
    assign rj_value  = w_res1[31:0];
    assign rkd_value = w_res2[31:0];

    assign w_ready_go   = ~(w_blk1 | w_blk2);
    assign id_exe_valid = r_valid & w_ready_go & ~flush;
    assign id_allowin   = ~r_valid | (w_ready_go & exe_allowin);

    assign w_eq   = rj_value == rkd_value;
    assign w_lt_s = $signed(rj_value) < $signed(rkd_value);
    assign w_lt_u = rj_value < rkd_value;

    always_comb begin
        w_cond = 1'b0;
        unique case (dec_br_op)
            3'd1:    w_cond = w_eq;
            3'd2:    w_cond = ~w_eq;
            3'd3:    w_cond = w_lt_s;
            3'd4:    w_cond = ~w_lt_s;
            3'd5:    w_cond = w_lt_u;
            3'd6:    w_cond = ~w_lt_u;
            3'd7:    w_cond = 1'b1;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_br_taken = w_cond & r_valid & w_ready_go & ~flush;
    assign id_if_bus  = {w_br_taken, dec_br_target};

    assign w_capture = if_id_valid & id_allowin & ~w_br_taken & ~flush;

    always_ff @(posedge clk) begin
        if (reset)
            r_valid <= 1'b0;
        else if (flush | w_br_taken)
            r_valid <= 1'b0;
        else if (id_allowin)
            r_valid <= if_id_valid;
    end

    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_pc   <= if_id_bus[63:32];
            r_inst <= if_id_bus[31:0];
        end
    end

    assign id_pc   = r_pc;
    assign id_inst = r_inst;

`ifdef ID_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            r_stall_cnt <= 32'h0;
        else if (r_valid & ~w_ready_go & ~flush & ~(&r_stall_cnt))
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_id_fwd_stage.sv
// Scoreboard bench for id_fwd_stage: driver pushes model predictions, monitor compares.
module tb_id_fwd_stage;

    localparam int NF = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_id_valid;
    logic              id_allowin;
    logic [63:0]       if_id_bus;
    logic              id_exe_valid;
    logic              exe_allowin;
    logic              flush;
    logic [31:0]       id_pc, id_inst;
    logic              dec_rj_used, dec_rk_used, dec_rd_src;
    logic [2:0]        dec_br_op;
    logic [31:0]       dec_br_target;
    logic [4:0]        rf_raddr1, rf_raddr2;
    logic [31:0]       rf_rdata1, rf_rdata2;
    logic [NF*39-1:0]  fwd_bus;
    logic [31:0]       rj_value, rkd_value;
    logic [32:0]       id_if_bus;
    logic [31:0]       stall_cnt;

    logic [31:0] regs [32];
    logic        ch_en  [NF];
    logic        ch_blk [NF];
    logic [4:0]  ch_dest[NF];
    logic [31:0] ch_wd  [NF];

    always #5 clk = ~clk;

    id_fwd_stage #(.NUM_FWD(NF)) dut (
        .clk(clk), .reset(reset),
        .if_id_valid(if_id_valid), .id_allowin(id_allowin),
        .if_id_bus(if_id_bus), .id_exe_valid(id_exe_valid),
        .exe_allowin(exe_allowin), .flush(flush),
        .id_pc(id_pc), .id_inst(id_inst),
        .dec_rj_used(dec_rj_used), .dec_rk_used(dec_rk_used),
        .dec_rd_src(dec_rd_src), .dec_br_op(dec_br_op),
        .dec_br_target(dec_br_target),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_bus(fwd_bus), .rj_value(rj_value), .rkd_value(rkd_value),
        .id_if_bus(id_if_bus), .stall_cnt(stall_cnt)
    );

    assign rf_rdata1 = regs[rf_raddr1];
    assign rf_rdata2 = regs[rf_raddr2];

    always_comb begin
        fwd_bus = '0;
        for (int k = 0; k < NF; k++)
            fwd_bus[39*k +: 39] = {ch_en[k], ch_blk[k], ch_dest[k], ch_wd[k]};
    end

    typedef struct packed {
        logic        v, ev, al, bt, c1, c2;
        logic [31:0] pc, inst, rj, rkd, tgt, cnt;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   tests = 0;
    int   fails = 0;

    logic        m_valid;
    logic [31:0] m_pc, m_inst, m_cnt;

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            chk("id_exe_valid", 32'(id_exe_valid), 32'(me.ev));
            chk("id_allowin", 32'(id_allowin), 32'(me.al));
            chk("br_taken", 32'(id_if_bus[32]), 32'(me.bt));
            chk("stall_cnt", stall_cnt, me.cnt);
            if (me.bt) chk("br_target", id_if_bus[31:0], me.tgt);
            if (me.v) begin
                chk("id_pc", id_pc, me.pc);
                chk("id_inst", id_inst, me.inst);
            end
            if (me.c1) chk("rj_value", rj_value, me.rj);
            if (me.c2) chk("rkd_value", rkd_value, me.rkd);
        end
    end

    // Reference: first channel in priority order naming the register wins.
    task automatic resolve(input logic [4:0] a, input logic used,
                           output logic [31:0] v, output logic b);
        b = 1'b0;
        v = (a == 5'd0) ? 32'h0 : regs[a];
        if (used && a != 5'd0) begin
            for (int k = 0; k < NF; k++) begin
                if (ch_en[k] && ch_dest[k] == a) begin
                    v = ch_wd[k];
                    b = ch_blk[k];
                    break;
                end
            end
        end
    endtask

    task automatic step();
        exp_t e;
        logic [4:0]  a1, a2;
        logic [31:0] v1, v2;
        logic b1, b2, rdy, cond, al, bt;
        a1 = m_inst[9:5];
        a2 = dec_rd_src ? m_inst[4:0] : m_inst[14:10];
        resolve(a1, dec_rj_used, v1, b1);
        resolve(a2, dec_rk_used, v2, b2);
        rdy = !(b1 || b2);
        case (dec_br_op)
            3'd1: cond = (v1 == v2);
            3'd2: cond = (v1 != v2);
            3'd3: cond = ($signed(v1) < $signed(v2));
            3'd4: cond = !($signed(v1) < $signed(v2));
            3'd5: cond = (v1 < v2);
            3'd6: cond = !(v1 < v2);
            3'd7: cond = 1'b1;
            default: cond = 1'b0;
        endcase
        al = !m_valid || (rdy && exe_allowin);
        bt = cond && m_valid && rdy && !flush;
        e.v    = m_valid;
        e.ev   = m_valid && rdy && !flush;
        e.al   = al;
        e.bt   = bt;
        e.c1   = m_valid && rdy && dec_rj_used;
        e.c2   = m_valid && rdy && dec_rk_used;
        e.pc   = m_pc;
        e.inst = m_inst;
        e.rj   = v1;
        e.rkd  = v2;
        e.tgt  = dec_br_target;
        e.cnt  = m_cnt;
        q.push_back(e);
        @(posedge clk);
        if (!reset && if_id_valid && al && !bt && !flush) begin
            m_pc   = if_id_bus[63:32];
            m_inst = if_id_bus[31:0];
        end
`ifdef ID_STALL_CNT_EN
        if (reset) m_cnt = 0;
        else if (m_valid && !rdy && !flush && m_cnt != 32'hFFFF_FFFF) m_cnt++;
`endif
        if (reset) m_valid = 1'b0;
        else if (flush || bt) m_valid = 1'b0;
        else if (al) m_valid = if_id_valid;
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [4:0] rd, rj, rk);
        logic [16:0] top;
        top = 17'($urandom);
        return {top, rk, rj, rd};
    endfunction

    task automatic clr();
        for (int k = 0; k < NF; k++) begin
            ch_en[k] = 1'b0; ch_blk[k] = 1'b0;
            ch_dest[k] = 5'd0; ch_wd[k] = 32'h0;
        end
        if_id_valid = 1'b0; flush = 1'b0; exe_allowin = 1'b1;
        dec_br_op = 3'd0;
    endtask

    task automatic setch(input int k, input logic en, blk,
                         input logic [4:0] d, input logic [31:0] w);
        ch_en[k] = en; ch_blk[k] = blk; ch_dest[k] = d; ch_wd[k] = w;
    endtask

    task automatic load(input logic [31:0] pc, input logic [31:0] inst);
        clr();
        if_id_valid = 1'b1;
        if_id_bus = {pc, inst};
        step();
        if_id_valid = 1'b0;
    endtask

    task automatic branch(input logic [2:0] op, input logic [31:0] a, b);
        load(32'h1000 + 32'(op), mk(5'd3, 5'd2, 5'd9));
        dec_rj_used = 1'b1; dec_rk_used = 1'b1; dec_rd_src = 1'b1;
        dec_br_op = op; dec_br_target = 32'h8000_0000 | 32'(op);
        setch(0, 1'b1, 1'b0, 5'd2, a);
        setch(1, 1'b1, 1'b0, 5'd3, b);
        if_id_valid = 1'b1;
        if_id_bus = {32'h2000, mk(5'd1, 5'd1, 5'd1)};
        step();
        clr();
        step();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = 32'hDEAD_BEEF;
        m_valid = 1'b0; m_pc = 0; m_inst = 0; m_cnt = 0;
        clr();
        reset = 1'b1;
        if_id_bus = 64'h0;
        dec_rj_used = 1'b0; dec_rk_used = 1'b0; dec_rd_src = 1'b0;
        dec_br_target = 32'h0;
        @(posedge clk); #1;
        step();
        reset = 1'b0;

        dec_rj_used = 1'b1; dec_rk_used = 1'b1; dec_rd_src = 1'b0;
        load(32'h100, mk(5'd3, 5'd1, 5'd2));
        setch(0, 1'b1, 1'b0, 5'd1, 32'h11);
        setch(2, 1'b1, 1'b0, 5'd1, 32'h33);
        step();

        load(32'h104, mk(5'd4, 5'd5, 5'd6));
        setch(0, 1'b1, 1'b1, 5'd5, 32'h0);
        step();
        setch(0, 1'b0, 1'b0, 5'd0, 32'h0);
        setch(1, 1'b1, 1'b0, 5'd5, 32'hABCD);
        step();
        clr();
        step();

        load(32'h108, mk(5'd4, 5'd0, 5'd6));
        setch(0, 1'b1, 1'b1, 5'd0, 32'h55);
        step();

        branch(3'd3, 32'hFFFF_FFFF, 32'h1);
        branch(3'd5, 32'hFFFF_FFFF, 32'h1);
        branch(3'd4, 32'h5, 32'h5);
        branch(3'd7, 32'h0, 32'h0);

        load(32'h10C, mk(5'd6, 5'd4, 5'd0));
        dec_rd_src = 1'b1; dec_br_op = 3'd1;
        setch(0, 1'b1, 1'b1, 5'd4, 32'h0);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        clr();
        dec_rd_src = 1'b0;

        load(32'h110, mk(5'd7, 5'd8, 5'd9));
        exe_allowin = 1'b0;
        if_id_valid = 1'b1;
        if_id_bus = {32'h114, mk(5'd1, 5'd2, 5'd3)};
        repeat (3) step();
        exe_allowin = 1'b1;
        step();
        clr();
        step();

        for (int n = 0; n < 3000; n++) begin
            reset         = ($urandom_range(0, 199) == 0);
            if_id_valid   = ($urandom_range(0, 3) != 0);
            if_id_bus     = {$urandom, mk(5'($urandom_range(0, 7)),
                                          5'($urandom_range(0, 7)),
                                          5'($urandom_range(0, 7)))};
            exe_allowin   = ($urandom_range(0, 4) != 0);
            flush         = ($urandom_range(0, 15) == 0);
            dec_rj_used   = ($urandom_range(0, 5) != 0);
            dec_rk_used   = ($urandom_range(0, 5) != 0);
            dec_rd_src    = 1'($urandom);
            dec_br_op     = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom);
            dec_br_target = $urandom;
            for (int k = 0; k < NF; k++) begin
                ch_en[k]   = 1'($urandom);
                ch_blk[k]  = ($urandom_range(0, 5) == 0);
                ch_dest[k] = 5'($urandom_range(0, 7));
                ch_wd[k]   = ($urandom_range(0, 2) == 0) ? 32'h5 : $urandom;
            end
            step();
        end
        reset = 1'b0;

        @(negedge clk);
        chk("queue_drain", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
